// File: rtl/uart_baud_gen_frac_if.sv
// ---------------------------------------------------------------------------
// uart_baud_gen_frac_if
// Divisor programming bus between the register interface (master) and the
// fractional baud generator (slave).
//
// Signals
//   div_int   [DIV_W-1:0]   integer cycles per oversample tick
//   div_frac  [FRAC_W-1:0]  fractional cycles per tick (units of 1/2^FRAC_W)
//   div_load  1             single-cycle load strobe
//
// Handshake: div_load acts as a valid with an implicit, always-high ready.
// The slave accepts the transfer in every cycle where div_load is high.
// div_int/div_frac only need to be stable in that cycle.
// ---------------------------------------------------------------------------
interface uart_baud_gen_frac_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;

    modport master (
        output div_int,
        output div_frac,
        output div_load
    );

    modport slave (
        input div_int,
        input div_frac,
        input div_load
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// uart_baud_gen_frac
// Fractional baud generator for the UART shift engines. It produces:
//   - an oversample tick (OVERSAMPLE per bit),
//   - bit-boundary and mid-bit strobes,
//   - a ~50% baud clock with rising/falling edge pulses.
// The divisor (integer + fraction) can be programmed at run time. RX can
// re-align the bit phase on a start edge.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_enable          1 = run, 0 = idle
//   div_bus           divisor programming bus (slave modport)
//   i_resync          strobe: restart bit phase (ignored unless running)
//   o_os_tick         pulse once per oversample period
//   o_baud_tick       pulse on the tick that wraps the phase to 0
//   o_mid_tick        pulse on the tick that sets the phase to OVERSAMPLE/2
//   o_baud_clk        1 while phase >= OVERSAMPLE/2
//   o_rising_edge     pulse when o_baud_clk goes 0->1
//   o_falling_edge    pulse when o_baud_clk goes 1->0
//   o_os_phase        oversample index within the bit
//   o_div_err         sticky: the last load requested div_int < 2
//   o_active          1 while in RUN
//   o_dbg_state       FSM state (0 IDLE, 1 RUN, 2 LOAD)
// ---------------------------------------------------------------------------
module uart_baud_gen_frac #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned DEFAULT_BAUD = 9600,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    localparam int unsigned PH_W        = $clog2(OVERSAMPLE)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    uart_baud_gen_frac_if.slave        div_bus,
    input  logic                       i_resync,
    output logic                       o_os_tick,
    output logic                       o_baud_tick,
    output logic                       o_mid_tick,
    output logic                       o_baud_clk,
    output logic                       o_rising_edge,
    output logic                       o_falling_edge,
    output logic [PH_W-1:0]            o_os_phase,
    output logic                       o_div_err,
    output logic                       o_active,
    output logic [1:0]                 o_dbg_state
);

    // Reset divisor in fixed point: CLK_HZ * 2^FRAC_W / (baud * OVERSAMPLE).
    localparam logic [63:0] DEF_TOTAL =
        (64'(CLK_HZ) << FRAC_W) / (64'(DEFAULT_BAUD) * 64'(OVERSAMPLE));
    localparam logic [DIV_W-1:0]  DEF_INT  = DEF_TOTAL[FRAC_W +: DIV_W];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_TOTAL[FRAC_W-1:0];

    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID     = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_PRE_MID = PH_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t            state_q;
    logic [DIV_W-1:0]  div_int_q;
    logic [FRAC_W-1:0] div_frac_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [FRAC_W-1:0] acc_q;
    logic              carry_q;

    logic              in_run;
    logic              clear_run;
    logic              tick_due;
    logic              fire;
    logic [DIV_W:0]    period;
    logic [DIV_W:0]    cnt_next;
    logic [PH_W-1:0]   ph_next;
    logic [FRAC_W:0]   acc_sum;

    // The carry from the previous tick stretches the current period by one
    // cycle. This spreads the fractional part evenly across the ticks.
    assign period   = {1'b0, div_int_q} + {{DIV_W{1'b0}}, carry_q};
    assign cnt_next = {1'b0, cnt_q} + {{DIV_W{1'b0}}, 1'b1};
    assign tick_due = (cnt_next == period);
    assign ph_next  = (o_os_phase == PH_LAST) ? '0 : o_os_phase + 1'b1;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, div_frac_q};

    assign in_run = (state_q == S_RUN);
    // A load, a disable or a resync clears the bit phase silently: no tick
    // or edge pulse is produced in the cycle the clear happens.
    assign clear_run = div_bus.div_load || (in_run && (!i_enable || i_resync));
    assign fire      = in_run && !clear_run && tick_due;

    assign o_dbg_state = state_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            div_int_q      <= DEF_INT;
            div_frac_q     <= DEF_FRAC;
            cnt_q          <= '0;
            acc_q          <= '0;
            carry_q        <= 1'b0;
            o_os_tick      <= 1'b0;
            o_baud_tick    <= 1'b0;
            o_mid_tick     <= 1'b0;
            o_baud_clk     <= 1'b0;
            o_rising_edge  <= 1'b0;
            o_falling_edge <= 1'b0;
            o_os_phase     <= '0;
            o_div_err      <= 1'b0;
            o_active       <= 1'b0;
        end else begin
            // FSM. A load wins over enable changes and resync.
            if (div_bus.div_load) begin
                state_q  <= S_LOAD;
                o_active <= 1'b0;
                if (div_bus.div_int < DIV_W'(2)) begin
                    // Smallest divisor that still yields distinct ticks.
                    div_int_q  <= DIV_W'(2);
                    div_frac_q <= '0;
                    o_div_err  <= 1'b1;
                end else begin
                    div_int_q  <= div_bus.div_int;
                    div_frac_q <= div_bus.div_frac;
                    o_div_err  <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_enable) begin
                            state_q  <= S_RUN;
                            o_active <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (!i_enable) begin
                            state_q  <= S_IDLE;
                            o_active <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        state_q  <= i_enable ? S_RUN : S_IDLE;
                        o_active <= i_enable;
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        o_active <= 1'b0;
                    end
                endcase
            end

            // Strobes. The edges coincide with the baud/mid ticks by construction.
            o_os_tick      <= fire;
            o_baud_tick    <= fire && (o_os_phase == PH_LAST);
            o_falling_edge <= fire && (o_os_phase == PH_LAST);
            o_mid_tick     <= fire && (o_os_phase == PH_PRE_MID);
            o_rising_edge  <= fire && (o_os_phase == PH_PRE_MID);

            // Tick timing datapath.
            if (clear_run || !in_run) begin
                cnt_q      <= '0;
                acc_q      <= '0;
                carry_q    <= 1'b0;
                o_os_phase <= '0;
                o_baud_clk <= 1'b0;
            end else if (tick_due) begin
                cnt_q              <= '0;
                {carry_q, acc_q}   <= acc_sum;
                o_os_phase         <= ph_next;
                o_baud_clk         <= (ph_next >= PH_MID);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
